// File: rtl/video_pkg.sv
// Shared video definitions: return-pipe ownership tags and raster timing.
// Used by the VRAM arbiter, the timing generator and the fetch logic.
package video_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } ret_tag_t;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    function automatic logic raster_active(input int hc, input int vc);
        return (hc < H_ACTIVE) && (vc < V_ACTIVE);
    endfunction

    function automatic logic hsync_on(input int hc);
        return (hc >= H_ACTIVE + H_FRONT) &&
               (hc <  H_ACTIVE + H_FRONT + H_SYNC);
    endfunction

    function automatic logic vsync_on(input int vc);
        return (vc >= V_ACTIVE + V_FRONT) &&
               (vc <  V_ACTIVE + V_FRONT + V_SYNC);
    endfunction

    function automatic logic h_last(input int hc);
        return hc == H_TOTAL - 1;
    endfunction

    function automatic logic v_last(input int vc);
        return vc == V_TOTAL - 1;
    endfunction

endpackage

// File: rtl/vram_return_pipe.sv
// Read-return path: tag shift aligned with the VRAM read latency,
// plus the registered rvalid/rdata demux to the two requesters.
module vram_return_pipe
    import video_pkg::*;
#(
    parameter int DataWidth = 8
) (
    input  logic                 inp_clock,
    input  logic                 inp_reset,
    input  logic                 inp_tag_valid,
    input  owner_t               inp_tag_owner,
    input  logic [DataWidth-1:0] inp_mem_rdata,
    output logic                 out_vid_rvalid,
    output logic [DataWidth-1:0] out_vid_rdata,
    output logic                 out_cpu_rvalid,
    output logic [DataWidth-1:0] out_cpu_rdata
);

    ret_tag_t             r_tag0;
    ret_tag_t             r_tag1;
    logic                 r_vid_rvalid;
    logic                 r_cpu_rvalid;
    logic [DataWidth-1:0] r_vid_rdata;
    logic [DataWidth-1:0] r_cpu_rdata;
    logic                 w_ret_vid;
    logic                 w_ret_cpu;

    // r_tag1 lines up with the cycle in which inp_mem_rdata is valid
    always_comb begin
        w_ret_vid = r_tag1.valid && (r_tag1.owner == OWN_VID);
        w_ret_cpu = r_tag1.valid && (r_tag1.owner == OWN_CPU);
    end

    always_ff @(posedge inp_clock or posedge inp_reset) begin
        if (inp_reset) begin
            r_tag0       <= '{valid: 1'b0, owner: OWN_NONE};
            r_tag1       <= '{valid: 1'b0, owner: OWN_NONE};
            r_vid_rvalid <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_vid_rdata  <= '0;
            r_cpu_rdata  <= '0;
        end else begin
            r_tag0       <= '{valid: inp_tag_valid, owner: inp_tag_owner};
            r_tag1       <= r_tag0;
            r_vid_rvalid <= w_ret_vid;
            r_cpu_rvalid <= w_ret_cpu;
            if (w_ret_vid) r_vid_rdata <= inp_mem_rdata;
            if (w_ret_cpu) r_cpu_rdata <= inp_mem_rdata;
        end
    end

    assign out_vid_rvalid = r_vid_rvalid;
    assign out_vid_rdata  = r_vid_rdata;
    assign out_cpu_rvalid = r_cpu_rvalid;
    assign out_cpu_rdata  = r_cpu_rdata;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between scanout fetch and CPU: raster-aware
// priority with a CPU starvation guard, registered issue, tagged returns.
module vram_arbiter
    import video_pkg::*;
#(
    parameter int AddrWidth     = 16,
    parameter int DataWidth     = 8,
    parameter int VideoBurstMax = 7
) (
    input  logic                 inp_clock,
    input  logic                 inp_reset,
    input  logic                 inp_vid_active,
    input  logic                 inp_vid_req,
    input  logic [AddrWidth-1:0] inp_vid_addr,
    output logic                 out_vid_gnt,
    output logic                 out_vid_rvalid,
    output logic [DataWidth-1:0] out_vid_rdata,
    input  logic                 inp_cpu_req,
    input  logic                 inp_cpu_we,
    input  logic [AddrWidth-1:0] inp_cpu_addr,
    input  logic [DataWidth-1:0] inp_cpu_wdata,
    output logic                 out_cpu_gnt,
    output logic                 out_cpu_rvalid,
    output logic [DataWidth-1:0] out_cpu_rdata,
    output logic                 out_mem_en,
    output logic                 out_mem_we,
    output logic [AddrWidth-1:0] out_mem_addr,
    output logic [DataWidth-1:0] out_mem_wdata,
    input  logic [DataWidth-1:0] inp_mem_rdata
);

    localparam int BurstWidth = $clog2(VideoBurstMax + 1);
    localparam logic [BurstWidth-1:0] BurstMax =
        BurstWidth'(VideoBurstMax);

    logic [BurstWidth-1:0] r_burst_cnt;
    logic                  r_mem_en;
    logic                  r_mem_we;
    logic [AddrWidth-1:0]  r_mem_addr;
    logic [DataWidth-1:0]  r_mem_wdata;

    logic   w_vid_wins;
    logic   w_vid_gnt;
    logic   w_cpu_gnt;
    logic   w_tag_valid;
    owner_t w_tag_owner;

    // Video wins uncontended, or in active display until the guard trips
    always_comb begin
        w_vid_wins  = !inp_cpu_req ||
                      (inp_vid_active && (r_burst_cnt != BurstMax));
        w_vid_gnt   = inp_vid_req && w_vid_wins;
        w_cpu_gnt   = inp_cpu_req && !w_vid_gnt;
        w_tag_valid = w_vid_gnt || (w_cpu_gnt && !inp_cpu_we);
        w_tag_owner = OWN_NONE;
        if (w_vid_gnt) begin
            w_tag_owner = OWN_VID;
        end else if (w_cpu_gnt && !inp_cpu_we) begin
            w_tag_owner = OWN_CPU;
        end
    end

    always_ff @(posedge inp_clock or posedge inp_reset) begin
        if (inp_reset) begin
            r_burst_cnt <= '0;
        end else if (!inp_cpu_req || w_cpu_gnt) begin
            r_burst_cnt <= '0;
        end else if (w_vid_gnt && (r_burst_cnt != BurstMax)) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
        end
    end

    always_ff @(posedge inp_clock or posedge inp_reset) begin
        if (inp_reset) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_en <= w_vid_gnt || w_cpu_gnt;
            r_mem_we <= w_cpu_gnt && inp_cpu_we;
            if (w_cpu_gnt) begin
                r_mem_addr <= inp_cpu_addr;
            end else if (w_vid_gnt) begin
                r_mem_addr <= inp_vid_addr;
            end
            if (w_cpu_gnt && inp_cpu_we) begin
                r_mem_wdata <= inp_cpu_wdata;
            end
        end
    end

    assign out_vid_gnt   = w_vid_gnt;
    assign out_cpu_gnt   = w_cpu_gnt;
    assign out_mem_en    = r_mem_en;
    assign out_mem_we    = r_mem_we;
    assign out_mem_addr  = r_mem_addr;
    assign out_mem_wdata = r_mem_wdata;

    vram_return_pipe #(
        .DataWidth(DataWidth)
    ) u_return_pipe (
        .inp_clock     (inp_clock),
        .inp_reset     (inp_reset),
        .inp_tag_valid (w_tag_valid),
        .inp_tag_owner (w_tag_owner),
        .inp_mem_rdata (inp_mem_rdata),
        .out_vid_rvalid(out_vid_rvalid),
        .out_vid_rdata (out_vid_rdata),
        .out_cpu_rvalid(out_cpu_rvalid),
        .out_cpu_rdata (out_cpu_rdata)
    );

endmodule
